// File: rtl/core_run_controller_pkg.sv
// Shared encodings and defaults for the core run controller and its helpers.
// Mode values match the switch-bank wiring on the board.
package core_run_controller_pkg;

    localparam int CNT_W_DEFAULT   = 16;
    localparam int RUN_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'b00,
        MODE_CSTEP = 2'b01,
        MODE_ISTEP = 2'b10,
        MODE_RUN   = 2'b11
    } runMode_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CSTEP      = 3'd1,
        ST_ISTEP      = 3'd2,
        ST_ISTEP_WAIT = 3'd3,
        ST_RUN        = 3'd4,
        ST_BREAK      = 3'd5
    } runState_t;

endpackage

// File: rtl/core_run_controller_run_tick_divider.sv
// Free-running modulo-RUN_DIV counter that paces core enables in run mode.
// owTick is high on the terminal count; iwClr holds the count at zero.
module run_tick_divider #(
    parameter int RUN_DIV = 4
) (
    input  logic iwClk,
    input  logic iwnRst,
    input  logic iwClr,
    output logic owTick
);

    localparam int W = $clog2(RUN_DIV);
    localparam logic [W-1:0] LAST = W'(RUN_DIV - 1);

    logic [W-1:0] divCnt;

    always_ff @(posedge iwClk) begin
        if (!iwnRst || iwClr) begin
            divCnt <= '0;
        end else if (divCnt == LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + W'(1);
        end
    end

    assign owTick = (divCnt == LAST);

endmodule

// File: rtl/core_run_controller.sv
// Execution sequencer for the multicycle core: halt, cycle-step, instruction-step,
// free-run and run-to-breakpoint, plus cycle/instruction counters for the display.
module core_run_controller
    import core_run_controller_pkg::*;
#(
    parameter int RUN_DIV = RUN_DIV_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             iwClk100M,
    input  logic             iwnRst,
    input  logic [1:0]       iwMode,
    input  logic             iwBrkEn,
    input  logic             iwStep,
    input  logic             iwAtBoundary,
    input  logic [31:0]      iwPc,
    input  logic [31:0]      iwBrkPc,
    input  logic             iwClrCnt,
    output logic             owCoreCe,
    output logic             owHalted,
    output logic             owBrkHit,
    output logic [CNT_W-1:0] owCycCnt,
    output logic [CNT_W-1:0] owInstrCnt
);

    runState_t state;
    runState_t stepState;
    runMode_t  mode;
    logic      stepCe;
    logic      skip;
    logic      runTick;
    logic      divClr;
    logic      brkMatch;

    assign mode     = runMode_t'(iwMode);
    assign divClr   = (state != ST_RUN);
    // skip lets a run resumed at the breakpoint PC execute that instruction once.
    assign brkMatch = iwBrkEn && iwAtBoundary && (iwPc == iwBrkPc) && !skip;

    // Where an accepted step pulse leads; shared by IDLE and BREAK.
    always_comb begin
        stepState = ST_IDLE;
        stepCe    = 1'b0;
        case (mode)
            MODE_CSTEP: begin
                stepState = ST_CSTEP;
                stepCe    = 1'b1;
            end
            MODE_ISTEP: begin
                stepState = ST_ISTEP;
                stepCe    = 1'b1;
            end
            MODE_RUN:  stepState = ST_RUN;
            default:   stepState = ST_IDLE;
        endcase
    end

    run_tick_divider #(
        .RUN_DIV(RUN_DIV)
    ) uDivider (
        .iwClk (iwClk100M),
        .iwnRst(iwnRst),
        .iwClr (divClr),
        .owTick(runTick)
    );

    always_ff @(posedge iwClk100M) begin
        if (!iwnRst) begin
            state    <= ST_IDLE;
            owCoreCe <= 1'b0;
            owHalted <= 1'b1;
            owBrkHit <= 1'b0;
            skip     <= 1'b0;
        end else begin
            owCoreCe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iwStep && (mode != MODE_HALT)) begin
                        state    <= stepState;
                        owCoreCe <= stepCe;
                        owHalted <= 1'b0;
                        if (mode == MODE_RUN) skip <= 1'b1;
                    end
                end
                ST_CSTEP: begin
                    state    <= ST_IDLE;
                    owHalted <= 1'b1;
                end
                ST_ISTEP: begin
                    state <= ST_ISTEP_WAIT;
                end
                ST_ISTEP_WAIT: begin
                    if (iwAtBoundary) begin
                        state    <= ST_IDLE;
                        owHalted <= 1'b1;
                    end else begin
                        state    <= ST_ISTEP;
                        owCoreCe <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (runTick) begin
                        if (brkMatch) begin
                            state    <= ST_BREAK;
                            owBrkHit <= 1'b1;
                            owHalted <= 1'b1;
                        end else if ((mode != MODE_RUN) && iwAtBoundary) begin
                            state    <= ST_IDLE;
                            owHalted <= 1'b1;
                        end else begin
                            owCoreCe <= 1'b1;
                            if (iwAtBoundary) skip <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (iwStep) begin
                        owBrkHit <= 1'b0;
                        state    <= stepState;
                        owCoreCe <= stepCe;
                        owHalted <= (mode == MODE_HALT);
                        if (mode == MODE_RUN) skip <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    owHalted <= 1'b1;
                end
            endcase
        end
    end

    // Counters follow the registered enable, so they are naturally frozen in IDLE/BREAK.
    always_ff @(posedge iwClk100M) begin
        if (!iwnRst || iwClrCnt) begin
            owCycCnt   <= '0;
            owInstrCnt <= '0;
        end else if (owCoreCe) begin
            owCycCnt <= owCycCnt + CNT_W'(1);
            if (iwAtBoundary) owInstrCnt <= owInstrCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: a 4-cycle-per-instruction core model reacts to
// owCoreCe, and a queue holds the exact cycle each enable pulse is due.
module tb_core_run_controller;

    localparam int RUN_DIV = 4;
    localparam int CNT_W   = 10;
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic [1:0]       mode = 2'b01;
    logic             brkEn = 1'b0;
    logic             step = 1'b0;
    logic             atBoundary;
    logic [31:0]      pc;
    logic [31:0]      brkPc = 32'h0;
    logic             clrCnt = 1'b0;
    logic             coreCe;
    logic             halted;
    logic             brkHit;
    logic [CNT_W-1:0] cycCnt;
    logic [CNT_W-1:0] instrCnt;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] expCeQ[$];
    logic [31:0] popped;

    logic        coreRstN = 1'b0;
    logic [1:0]  phase;
    logic [31:0] corePc;

    core_run_controller #(
        .RUN_DIV(RUN_DIV),
        .CNT_W  (CNT_W)
    ) dut (
        .iwClk100M   (clk),
        .iwnRst      (nRst),
        .iwMode      (mode),
        .iwBrkEn     (brkEn),
        .iwStep      (step),
        .iwAtBoundary(atBoundary),
        .iwPc        (pc),
        .iwBrkPc     (brkPc),
        .iwClrCnt    (clrCnt),
        .owCoreCe    (coreCe),
        .owHalted    (halted),
        .owBrkHit    (brkHit),
        .owCycCnt    (cycCnt),
        .owInstrCnt  (instrCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: four enables per instruction, fetch state at phase 0.
    always @(posedge clk) begin
        if (!coreRstN) begin
            phase  <= 2'd0;
            corePc <= 32'h0;
        end else if (coreCe === 1'b1) begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) corePc <= corePc + 32'd4;
        end
    end
    assign atBoundary = (phase == 2'd0);
    assign pc         = corePc;

    // Every enable pulse must match the next due cycle in the queue.
    always @(negedge clk) begin
        if (coreCe === 1'b1) begin
            vectors++;
            if (expCeQ.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ce: got coreCe=1 at cycle %0d, required no enable", cyc);
            end else begin
                popped = expCeQ.pop_front();
                if (popped !== 32'(cyc)) begin
                    miscompares++;
                    $display("FAIL ce_timing: got enable at cycle %0d, required cycle %0d", cyc, popped);
                end
            end
        end
    end

    task automatic stepPulse(input int firstOff, input int count, input int period, output int c);
        @(negedge clk);
        step = 1'b1;
        c = cyc;
        for (int n = 0; n < count; n++) expCeQ.push_back(32'(c + firstOff + n * period));
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic resetCore();
        @(negedge clk);
        coreRstN = 1'b0;
        @(negedge clk);
        coreRstN = 1'b1;
    endtask

    task automatic clearCounters();
        @(negedge clk);
        clrCnt = 1'b1;
        @(negedge clk);
        clrCnt = 1'b0;
    endtask

    // Starts a run (nCe a multiple of 4, >= 8), drops to halt mode while the boundary
    // is low, and waits for the graceful stop after exactly nCe enables.
    task automatic runAndStop(input int nCe, output logic haltedMid, output bit timedOut);
        int c;
        stepPulse(5, nCe, 4, c);
        repeat (4 * (nCe - 3)) @(negedge clk);
        haltedMid = halted;
        mode = 2'b00;
        timedOut = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (coreCe !== 1'b0) begin miscompares++; $display("FAIL reset_ce: got %b, required 0", coreCe); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL reset_halted: got %b, required 1", halted); end
        vectors++; if (brkHit !== 1'b0) begin miscompares++; $display("FAIL reset_brk: got %b, required 0", brkHit); end
        vectors++; if (cycCnt !== '0) begin miscompares++; $display("FAIL reset_cyc: got %0d, required 0", cycCnt); end
        vectors++; if (instrCnt !== '0) begin miscompares++; $display("FAIL reset_instr: got %0d, required 0", instrCnt); end
        nRst = 1'b1;
        coreRstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cycle_step();
        int c;
        mode = 2'b00;
        stepPulse(1, 0, 0, c);
        repeat (4) @(negedge clk);
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_mode_step: got halted=%b, required 1", halted); end
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            stepPulse(1, 1, 0, c);
            vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL cstep_busy: got halted=%b, required 0", halted); end
            repeat (9) @(negedge clk);
        end
        vectors++; if (cycCnt !== CNT_W'(3)) begin miscompares++; $display("FAIL cstep_cyc: got %0d, required 3", cycCnt); end
        vectors++; if (instrCnt !== CNT_W'(1)) begin miscompares++; $display("FAIL cstep_instr: got %0d, required 1", instrCnt); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL cstep_halted: got %b, required 1", halted); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL cstep_missing: got %0d pending, required 0", expCeQ.size()); end
    endtask

    task automatic test_instr_step();
        int c;
        resetCore();
        clearCounters();
        mode = 2'b10;
        stepPulse(1, 4, 2, c);
        // A pulse while the step is in flight must be dropped.
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (14) @(negedge clk);
        vectors++; if (cycCnt !== CNT_W'(4)) begin miscompares++; $display("FAIL istep_cyc: got %0d, required 4", cycCnt); end
        vectors++; if (instrCnt !== CNT_W'(1)) begin miscompares++; $display("FAIL istep_instr: got %0d, required 1", instrCnt); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL istep_halted: got %b, required 1", halted); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL istep_missing: got %0d pending, required 0", expCeQ.size()); end
    endtask

    task automatic test_run_graceful_stop();
        logic haltedMid;
        bit   timedOut;
        resetCore();
        clearCounters();
        brkEn = 1'b0;
        mode = 2'b11;
        runAndStop(8, haltedMid, timedOut);
        vectors++; if (haltedMid !== 1'b0) begin miscompares++; $display("FAIL run_busy: got halted=%b, required 0", haltedMid); end
        vectors++; if (timedOut) begin miscompares++; $display("FAIL run_stop_timeout: got no halt in 40 cycles, required halt"); end
        vectors++; if (cycCnt !== CNT_W'(8)) begin miscompares++; $display("FAIL run_cyc: got %0d, required 8", cycCnt); end
        vectors++; if (instrCnt !== CNT_W'(2)) begin miscompares++; $display("FAIL run_instr: got %0d, required 2", instrCnt); end
        vectors++; if (brkHit !== 1'b0) begin miscompares++; $display("FAIL run_brk: got %b, required 0", brkHit); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL run_missing: got %0d pending, required 0", expCeQ.size()); end
    endtask

    task automatic test_breakpoint();
        int   c;
        bit   timedOut;
        logic haltedMid;
        resetCore();
        clearCounters();
        brkEn = 1'b1;
        brkPc = 32'h0000_0010;
        mode = 2'b11;
        stepPulse(5, 16, 4, c);
        timedOut = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
        repeat (5) @(negedge clk);
        vectors++; if (timedOut) begin miscompares++; $display("FAIL brk_timeout: got no halt in 100 cycles, required halt"); end
        vectors++; if (brkHit !== 1'b1) begin miscompares++; $display("FAIL brk_hit: got %b, required 1", brkHit); end
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL brk_pc: got %h, required 00000010", pc); end
        vectors++; if (cycCnt !== CNT_W'(16)) begin miscompares++; $display("FAIL brk_cyc: got %0d, required 16", cycCnt); end
        vectors++; if (instrCnt !== CNT_W'(4)) begin miscompares++; $display("FAIL brk_instr: got %0d, required 4", instrCnt); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL brk_missing: got %0d pending, required 0", expCeQ.size()); end
        runAndStop(8, haltedMid, timedOut);
        vectors++; if (timedOut) begin miscompares++; $display("FAIL resume_timeout: got no halt in 40 cycles, required halt"); end
        vectors++; if (brkHit !== 1'b0) begin miscompares++; $display("FAIL resume_brk: got %b, required 0", brkHit); end
        vectors++; if (pc !== 32'h18) begin miscompares++; $display("FAIL resume_pc: got %h, required 00000018", pc); end
        vectors++; if (cycCnt !== CNT_W'(24)) begin miscompares++; $display("FAIL resume_cyc: got %0d, required 24", cycCnt); end
        vectors++; if (instrCnt !== CNT_W'(6)) begin miscompares++; $display("FAIL resume_instr: got %0d, required 6", instrCnt); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL resume_missing: got %0d pending, required 0", expCeQ.size()); end
        brkEn = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int c;
        mode = 2'b01;
        clearCounters();
        for (int i = 0; i < int'(ALL_ONES); i++) stepPulse(1, 1, 0, c);
        @(negedge clk);
        vectors++; if (cycCnt !== ALL_ONES) begin miscompares++; $display("FAIL wrap_full: got %0h, required %0h", cycCnt, ALL_ONES); end
        stepPulse(1, 1, 0, c);
        @(negedge clk);
        vectors++; if (cycCnt !== '0) begin miscompares++; $display("FAIL wrap_zero: got %0h, required 0", cycCnt); end
        for (int i = 0; i < int'(ALL_ONES); i++) stepPulse(1, 1, 0, c);
        @(negedge clk);
        vectors++; if (cycCnt !== ALL_ONES) begin miscompares++; $display("FAIL wrap_full2: got %0h, required %0h", cycCnt, ALL_ONES); end
        // Clear lands in the same cycle as the enable.
        stepPulse(1, 1, 0, c);
        clrCnt = 1'b1;
        @(negedge clk);
        clrCnt = 1'b0;
        vectors++; if (cycCnt !== '0) begin miscompares++; $display("FAIL clr_vs_ce_full: got %0h, required 0", cycCnt); end
        vectors++; if (instrCnt !== '0) begin miscompares++; $display("FAIL clr_instr: got %0h, required 0", instrCnt); end
        stepPulse(1, 1, 0, c);
        stepPulse(1, 1, 0, c);
        stepPulse(1, 1, 0, c);
        clrCnt = 1'b1;
        @(negedge clk);
        clrCnt = 1'b0;
        vectors++; if (cycCnt !== '0) begin miscompares++; $display("FAIL clr_vs_ce_mid: got %0h, required 0", cycCnt); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL wrap_missing: got %0d pending, required 0", expCeQ.size()); end
    endtask

    task automatic test_reset_mid_run();
        int c;
        resetCore();
        mode = 2'b11;
        stepPulse(5, 2, 4, c);
        repeat (11) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        vectors++; if (coreCe !== 1'b0) begin miscompares++; $display("FAIL rst_run_ce: got %b, required 0", coreCe); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL rst_run_halted: got %b, required 1", halted); end
        vectors++; if (brkHit !== 1'b0) begin miscompares++; $display("FAIL rst_run_brk: got %b, required 0", brkHit); end
        vectors++; if (cycCnt !== '0) begin miscompares++; $display("FAIL rst_run_cyc: got %0d, required 0", cycCnt); end
        vectors++; if (instrCnt !== '0) begin miscompares++; $display("FAIL rst_run_instr: got %0d, required 0", instrCnt); end
        repeat (12) @(negedge clk);
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL rst_run_stays: got halted=%b, required 1", halted); end
        vectors++; if (expCeQ.size() != 0) begin miscompares++; $display("FAIL rst_run_missing: got %0d pending, required 0", expCeQ.size()); end
    endtask

    initial begin
        test_reset();
        test_cycle_step();
        test_instr_step();
        test_run_graceful_stop();
        test_breakpoint();
        test_counter_wrap();
        test_reset_mid_run();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
